// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a built-in TX FIFO and run-time frame configuration.
//   Characters pushed over a valid/ready interface are serialised LSB-first as
//   start bit, 5..9 data bits, optional parity bit and one or two stop bits.
//   Frame configuration is captured when a character leaves the FIFO and held
//   for the whole frame.
//
// Parameters
//   FIFO_DEPTH    TX FIFO entries (power of two, >= 2)
//   DIV_W         width of the baud divisor
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   s_valid       character valid
//   s_ready       FIFO not full
//   s_data        character; only the low cfg_data_bits bits are transmitted
//   cfg_div       bit period = cfg_div + 1 clock cycles
//   cfg_data_bits data length 5..9 (smaller values act as 5, larger as 9)
//   cfg_parity    0 none, 1 odd, 2 even, 3 none
//   cfg_stop2     0 one stop bit, 1 two stop bits
//   cts_n         clear-to-send, active-low (only with UART_TX_CTS_EN)
//   tx            registered serial output, idle high
//   busy          frame in progress
//   fifo_level    number of FIFO entries
//
// Build option
//   UART_TX_CTS_EN  adds the cts_n input, synchronised by two flops; a frame
//                   may only start while the synchronised cts_n is low.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [8:0]                  s_data,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [3:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
`ifdef UART_TX_CTS_EN
    input  logic                        cts_n,
`endif
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [8:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [LW-1:0]     count_q;
    logic [DIV_W-1:0]  timer_q, timer_d;
    logic [DIV_W-1:0]  divLat_q;
    logic [3:0]        nbits_q;
    logic              parEn_q, parBit_q, stop2_q;
    logic [8:0]        shift_q;
    logic [3:0]        bitCnt_q;
    logic              stopCnt_q;
    logic              tx_q, busy_q;

    logic              push, loadFrame, bitEnd, canStart, ctsOk, txBit;
    logic [8:0]        headData, dataMask, headMasked;
    logic [3:0]        nbitsIn;
    logic              parityNew, parEnNew;

`ifdef UART_TX_CTS_EN
    logic ctsMeta_q, ctsSync_q;

    // Synchroniser resets to "not clear" so nothing starts before cts_n is seen low.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctsMeta_q <= 1'b1;
            ctsSync_q <= 1'b1;
        end else begin
            ctsMeta_q <= cts_n;
            ctsSync_q <= ctsMeta_q;
        end
    end
    assign ctsOk = ~ctsSync_q;
`else
    assign ctsOk = 1'b1;
`endif

    assign s_ready    = (count_q != LW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign headData   = mem[rdPtr_q];
    assign canStart   = (count_q != '0) && ctsOk;
    assign bitEnd     = (timer_q == divLat_q);
    assign fifo_level = count_q;
    assign tx         = tx_q;
    assign busy       = busy_q;

    // Storage has no reset; emptying the pointers and count discards contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (loadFrame) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, loadFrame})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Clamp the data length, then derive the parity over only the bits sent.
    always_comb begin
        nbitsIn = cfg_data_bits;
        if (cfg_data_bits < 4'd5) begin
            nbitsIn = 4'd5;
        end else if (cfg_data_bits > 4'd9) begin
            nbitsIn = 4'd9;
        end
        dataMask = '0;
        for (int i = 0; i < 9; i++) begin
            dataMask[i] = (i < int'(nbitsIn));
        end
        headMasked = headData & dataMask;
        parEnNew   = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
        parityNew  = (cfg_parity == 2'd1) ? ~^headMasked : ^headMasked;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The last stop bit can hand straight over to the next frame's start bit.
    always_comb begin
        state_d   = state_q;
        loadFrame = 1'b0;
        case (state_q)
            IDLE: begin
                if (canStart) begin
                    state_d   = START;
                    loadFrame = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitEnd && (bitCnt_q == nbits_q - 4'd1)) begin
                    state_d = parEn_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bitEnd && (!stop2_q || stopCnt_q)) begin
                    if (canStart) begin
                        state_d   = START;
                        loadFrame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txBit = 1'b1;
        case (state_q)
            START:   txBit = 1'b0;
            DATA:    txBit = shift_q[0];
            PARITY:  txBit = parBit_q;
            default: txBit = 1'b1;
        endcase
    end

    // Timer restarts at every bit boundary and rests at zero while idle.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if ((state_q == IDLE) || bitEnd) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            divLat_q  <= '0;
            nbits_q   <= 4'd5;
            parEn_q   <= 1'b0;
            parBit_q  <= 1'b0;
            stop2_q   <= 1'b0;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            if (loadFrame) begin
                shift_q   <= headData;
                divLat_q  <= cfg_div;
                nbits_q   <= nbitsIn;
                parEn_q   <= parEnNew;
                parBit_q  <= parityNew;
                stop2_q   <= cfg_stop2;
                bitCnt_q  <= '0;
                stopCnt_q <= 1'b0;
            end else if (bitEnd) begin
                if (state_q == DATA) begin
                    shift_q  <= {1'b0, shift_q[8:1]};
                    bitCnt_q <= bitCnt_q + 1'b1;
                end
                if (state_q == STOP) begin
                    stopCnt_q <= 1'b1;
                end
            end
        end
    end

    // Line and busy are registered, so both trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= txBit;
            busy_q <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Scoreboard bench for uart_tx_fifo. Stimulus pushes characters and queues
//   the hand-computed frame each one must produce; a monitor watches tx,
//   pops the next expected frame on every start bit and checks each bit level
//   and its duration, the start cycle and back-to-back spacing.
module tb_uart_tx_fifo;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    typedef struct {
        logic [12:0] bits;
        int          nBits;
        int          period;
        int          expStart;
        bit          gapless;
        bit          mayAbort;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sValid = 1'b0;
    logic             sReady;
    logic [8:0]       sData = '0;
    logic [DIV_W-1:0] cfgDiv = 16'd3;
    logic [3:0]       cfgDataBits = 4'd8;
    logic [1:0]       cfgParity = 2'd0;
    logic             cfgStop2 = 1'b0;
`ifdef UART_TX_CTS_EN
    logic             ctsN = 1'b0;
`endif
    logic             tx;
    logic             busy;
    logic [LW-1:0]    fifoLevel;

    int     vectors = 0;
    int     miscompares = 0;
    int     cycle = 0;
    bit     monActive = 1'b0;
    frame_t expQ[$];

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_W(DIV_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(sValid),
        .s_ready(sReady),
        .s_data(sData),
        .cfg_div(cfgDiv),
        .cfg_data_bits(cfgDataBits),
        .cfg_parity(cfgParity),
        .cfg_stop2(cfgStop2),
`ifdef UART_TX_CTS_EN
        .cts_n(ctsN),
`endif
        .tx(tx),
        .busy(busy),
        .fifo_level(fifoLevel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got timeout/abort, required completion", name);
    endtask

    // Called just after a rising edge; returns the cycle of the accepting edge.
    task automatic applyStimulus(input logic [8:0] d, output int pushCyc);
        int waitCnt;
        waitCnt = 0;
        sValid = 1'b1;
        sData  = d;
        while (!sReady && waitCnt < 3000) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!sReady) begin
            failNow("pushTimeout");
        end
        @(posedge clk); #1;
        pushCyc = cycle;
        sValid  = 1'b0;
    endtask

    task automatic expectFrame(input logic [12:0] bits, input int n, input int period,
                               input int start, input bit gapless, input bit mayAbort);
        frame_t f;
        f.bits     = bits;
        f.nBits    = n;
        f.period   = period;
        f.expStart = start;
        f.gapless  = gapless;
        f.mayAbort = mayAbort;
        expQ.push_back(f);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || monActive) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (expQ.size() != 0 || monActive) begin
            failNow({name, "_drain"});
        end else begin
            checkOutput({name, "_idleBusy"}, busy, 0);
            checkOutput({name, "_idleTx"}, tx, 1);
            checkOutput({name, "_idleLevel"}, fifoLevel, 0);
        end
    endtask

    initial begin : monitorProc
        frame_t cur;
        int     bitIdx;
        int     cyc;
        int     frameNo;
        int     lastEnd;
        int     junkCnt;
        logic   badSeen;
        logic   badVal;
        logic   busyOk;
        bitIdx  = 0;
        cyc     = 0;
        frameNo = 0;
        lastEnd = -10;
        junkCnt = 0;
        badSeen = 1'b0;
        badVal  = 1'b0;
        busyOk  = 1'b1;
        forever begin
            @(negedge clk);
            if (junkCnt > 0) begin
                junkCnt--;
            end
            if (rst) begin
                if (monActive && !cur.mayAbort) begin
                    failNow("frameCutByReset");
                end
                monActive = 1'b0;
            end else begin
                if (!monActive && junkCnt == 0 && tx === 1'b0) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedStart", tx, 1);
                        junkCnt = 200;
                    end else begin
                        cur = expQ.pop_front();
                        frameNo++;
                        monActive = 1'b1;
                        bitIdx  = 0;
                        cyc     = 0;
                        badSeen = 1'b0;
                        busyOk  = 1'b1;
                        if (cur.expStart >= 0) begin
                            checkOutput($sformatf("frame%0d_startCycle", frameNo), cycle, cur.expStart);
                        end
                        if (cur.gapless) begin
                            checkOutput($sformatf("frame%0d_gap", frameNo), cycle, lastEnd + 1);
                        end
                    end
                end
                if (monActive) begin
                    if (tx !== cur.bits[bitIdx] && !badSeen) begin
                        badSeen = 1'b1;
                        badVal  = tx;
                    end
                    if (busy !== 1'b1) begin
                        busyOk = 1'b0;
                    end
                    cyc++;
                    if (cyc == cur.period) begin
                        checkOutput($sformatf("frame%0d_bit%0d", frameNo, bitIdx),
                                    badSeen ? badVal : cur.bits[bitIdx], cur.bits[bitIdx]);
                        bitIdx++;
                        cyc     = 0;
                        badSeen = 1'b0;
                        if (bitIdx == cur.nBits) begin
                            checkOutput($sformatf("frame%0d_busy", frameNo), busyOk, 1);
                            monActive = 1'b0;
                            lastEnd   = cycle;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got no end of run, required $finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimProc
        int pc;
        int p0;
        int c;
        int n;
        logic [8:0] d;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("resetTx", tx, 1);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetLevel", fifoLevel, 0);
        checkOutput("resetReady", sReady, 1);
        waitCycles(1);

        // 8N1, 4-cycle bits, 0xA5 -> start, 1,0,1,0,0,1,0,1, stop
        cfgDiv = 16'd3; cfgDataBits = 4'd8; cfgParity = 2'd0; cfgStop2 = 1'b0;
        applyStimulus(9'h0A5, pc);
        expectFrame(13'({1'b1, 8'hA5, 1'b0}), 10, 4, pc + 2, 1'b0, 1'b0);
        checkOutput("t1_levelAfterPush", fifoLevel, 1);
        waitCycles(1);
        checkOutput("t1_levelAfterPop", fifoLevel, 0);
        checkOutput("t1_busyBeforeStart", busy, 0);
        waitCycles(1);
        checkOutput("t1_busyAtStart", busy, 1);
        waitDrain("t1");

        // 7 data bits, odd parity, two stops; bit 8 and bit 7 must be ignored
        cfgDiv = 16'd2; cfgDataBits = 4'd7; cfgParity = 2'd1; cfgStop2 = 1'b1;
        applyStimulus(9'h183, pc);
        expectFrame(13'({2'b11, 1'b1, 7'b0000011, 1'b0}), 11, 3, pc + 2, 1'b0, 1'b0);
        waitDrain("t2odd");

        // 8 data bits, even parity, one stop: 0x03 -> parity 0
        cfgDataBits = 4'd8; cfgParity = 2'd2; cfgStop2 = 1'b0;
        applyStimulus(9'h003, pc);
        expectFrame(13'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 3, pc + 2, 1'b0, 1'b0);
        waitDrain("t2even");

        // Length 2 acts as 5, parity code 3 acts as none, one clk per bit
        cfgDiv = 16'd0; cfgDataBits = 4'd2; cfgParity = 2'd3; cfgStop2 = 1'b0;
        applyStimulus(9'h1F5, pc);
        expectFrame(13'({1'b1, 5'b10101, 1'b0}), 7, 1, pc + 2, 1'b0, 1'b0);
        waitDrain("tClampLow");

        // Length 15 acts as 9, even parity over 0x1C3 (five ones) -> 1
        cfgDiv = 16'd1; cfgDataBits = 4'd15; cfgParity = 2'd2; cfgStop2 = 1'b0;
        applyStimulus(9'h1C3, pc);
        expectFrame(13'({1'b1, 1'b1, 9'h1C3, 1'b0}), 12, 2, pc + 2, 1'b0, 1'b0);
        waitDrain("tClampHigh");

        // Divisor change mid-frame only affects the following frame
        cfgDiv = 16'd3; cfgDataBits = 4'd8; cfgParity = 2'd0; cfgStop2 = 1'b0;
        applyStimulus(9'h0C3, pc);
        expectFrame(13'({1'b1, 8'hC3, 1'b0}), 10, 4, pc + 2, 1'b0, 1'b0);
        applyStimulus(9'h03C, pc);
        expectFrame(13'({1'b1, 8'h3C, 1'b0}), 10, 8, -1, 1'b1, 1'b0);
        waitCycles(10);
        cfgDiv = 16'd7;
        waitDrain("tDivChange");
        cfgDiv = 16'd3;

        // FIFO_DEPTH+1 pushes back-to-back: one popped, FIFO then full
        p0 = 0;
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            d = 9'(i * 13 + 5);
            applyStimulus(d, pc);
            if (i == 0) begin
                p0 = pc;
            end
            expectFrame(13'({1'b1, d[7:0], 1'b0}), 10, 4, (i == 0) ? pc + 2 : -1, i != 0, 1'b0);
        end
        checkOutput("burst_readyFull", sReady, 0);
        checkOutput("burst_levelFull", fifoLevel, FIFO_DEPTH);
        sValid = 1'b1;
        sData  = 9'h0AA;
        waitCycles(1);
        checkOutput("burst_pushWhileFullLevel", fifoLevel, FIFO_DEPTH);
        waitCycles(1);
        sValid = 1'b0;
        n = 0;
        while (cycle < p0 + 40 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("burst_readyBeforePop", sReady, 0);
        waitCycles(1);
        checkOutput("burst_readyAfterPop", sReady, 1);
        checkOutput("burst_levelAfterPop", fifoLevel, FIFO_DEPTH - 1);
        waitDrain("burst");

        // Reset mid-DATA with three characters still queued
        applyStimulus(9'h0F0, pc);
        expectFrame(13'({1'b1, 8'hF0, 1'b0}), 10, 4, pc + 2, 1'b0, 1'b1);
        applyStimulus(9'h011, pc);
        applyStimulus(9'h022, pc);
        applyStimulus(9'h033, pc);
        waitCycles(8);
        checkOutput("rst_levelBefore", fifoLevel, 3);
        checkOutput("rst_busyBefore", busy, 1);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_level", fifoLevel, 0);
        checkOutput("rst_ready", sReady, 1);
        waitCycles(150);
        checkOutput("rst_levelLater", fifoLevel, 0);
        checkOutput("rst_busyLater", busy, 0);

`ifdef UART_TX_CTS_EN
        // Held off by cts_n, then released, then held off mid-frame
        ctsN = 1'b1;
        waitCycles(1);
        applyStimulus(9'h055, pc);
        applyStimulus(9'h00F, pc);
        waitCycles(30);
        checkOutput("cts_heldBusy", busy, 0);
        checkOutput("cts_heldTx", tx, 1);
        checkOutput("cts_heldLevel", fifoLevel, 2);
        c = cycle;
        ctsN = 1'b0;
        expectFrame(13'({1'b1, 8'h55, 1'b0}), 10, 4, c + 4, 1'b0, 1'b0);
        waitCycles(20);
        ctsN = 1'b1;
        n = 0;
        while ((monActive || expQ.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (monActive || expQ.size() != 0) begin
            failNow("cts_firstFrame");
        end
        waitCycles(20);
        checkOutput("cts_secondWaitsBusy", busy, 0);
        checkOutput("cts_secondWaitsLevel", fifoLevel, 1);
        c = cycle;
        ctsN = 1'b0;
        expectFrame(13'({1'b1, 8'h0F, 1'b0}), 10, 4, c + 4, 1'b0, 1'b0);
        waitDrain("cts");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
